inst_axi_bridge: RTL and testbench

// Converts the fetch stage's inst-SRAM-like request/response port (en/addr_ok/data_ok) into an AXI read master.

---
 rtl/inst_axi_bridge_pkg.sv | 17 +
 rtl/inst_axi_bridge_if.sv | 56 +++++
 rtl/inst_axi_bridge.sv | 74 +++++++
 tb/tb_inst_axi_bridge.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/inst_axi_bridge_pkg.sv
// Shared constants and state type for the instruction-fetch AXI read bridge.
package inst_axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] INST_AR_ID     = 4'd0;
  // Word fetch is the natural size before any request has been seen
  localparam logic [1:0] RESET_SIZE     = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_RESP
  } bridge_state_t;

endpackage

// File: rtl/inst_axi_bridge_if.sv
// Fetch-side SRAM-like port plus AXI read address/data channels of the bridge.
interface inst_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              inst_sram_en;
  logic              inst_sram_wr;
  logic [1:0]        inst_sram_size;
  logic [3:0]        inst_sram_wen;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [DATA_W-1:0] inst_sram_wdata;
  logic              inst_sram_addr_ok;
  logic              inst_sram_data_ok;
  logic [DATA_W-1:0] inst_sram_rdata;

  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  // The bridge is the AXI master and the responder on the SRAM-like side
  modport master (
    input  inst_sram_en, inst_sram_wr, inst_sram_size, inst_sram_wen,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_sram_en, inst_sram_wr, inst_sram_size, inst_sram_wen,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/inst_axi_bridge.sv
// Single-outstanding AXI read master serving the fetch stage's SRAM-like port.
// Bus-facing valid/ready and data_ok come straight from the state register.
module inst_axi_bridge
  import inst_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AR_ID  = INST_AR_ID,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  inst_axi_bridge_if.master  bus
);

  bridge_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              r_done;
  logic              unused_inputs;

  assign accept = (state_q == ST_IDLE) && bus.inst_sram_en && !bus.inst_sram_wr;
  assign r_done = (state_q == ST_R) && bus.rvalid && bus.rlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= RESET_SIZE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= bus.inst_sram_addr;
        size_q <= bus.inst_sram_size;
      end
      if (r_done) begin
        rdata_q <= bus.rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)                    state_d = ST_AR;
      ST_AR:   if (bus.arready)               state_d = ST_R;
      // Beats without rlast are dropped; only the final beat completes
      ST_R:    if (bus.rvalid && bus.rlast)   state_d = ST_RESP;
      ST_RESP:                                state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  assign bus.inst_sram_addr_ok = accept;
  assign bus.inst_sram_data_ok = (state_q == ST_RESP);
  assign bus.inst_sram_rdata   = rdata_q;

  assign bus.arid    = AR_ID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = (state_q == ST_AR);
  assign bus.rready  = (state_q == ST_R);

  // Error responses and IDs are deliberately not acted upon
  assign unused_inputs = ^{bus.inst_sram_wen, bus.inst_sram_wdata, bus.rid, bus.rresp};

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge: single fetches, stalls, back-to-back, writes, reset, error resp.
module tb_inst_axi_bridge;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  inst_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_axi_bridge #(.AR_ID(4'd0), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One full fetch; inputs change on the falling edge and outputs are sampled 1 ns later
  task automatic runFetch(input string tag, input logic [31:0] addr, input int arWait, input int rWait,
                          input logic [31:0] data, input logic [1:0] resp, input bit holdEn);
    @(negedge clk);
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_wr   = 1'b0;
    bus.inst_sram_addr = addr;
    bus.inst_sram_size = 2'b10;
    #1;
    checkOutput({tag, ".addr_ok"}, 64'(bus.inst_sram_addr_ok), 64'd1);
    checkOutput({tag, ".idle_data_ok"}, 64'(bus.inst_sram_data_ok), 64'd0);
    checkOutput({tag, ".idle_arvalid"}, 64'(bus.arvalid), 64'd0);
    @(negedge clk);
    bus.inst_sram_en   = holdEn;
    bus.inst_sram_addr = 32'hffff_fff0;
    for (int i = 0; i < arWait; i++) begin
      #1;
      checkOutput({tag, ".stall_arvalid"}, 64'(bus.arvalid), 64'd1);
      checkOutput({tag, ".stall_araddr"}, 64'(bus.araddr), 64'(addr));
      checkOutput({tag, ".stall_addr_ok"}, 64'(bus.inst_sram_addr_ok), 64'd0);
      @(negedge clk);
    end
    bus.arready = 1'b1;
    #1;
    checkOutput({tag, ".arvalid"}, 64'(bus.arvalid), 64'd1);
    checkOutput({tag, ".araddr"}, 64'(bus.araddr), 64'(addr));
    checkOutput({tag, ".arsize"}, 64'(bus.arsize), 64'd2);
    checkOutput({tag, ".ar_addr_ok"}, 64'(bus.inst_sram_addr_ok), 64'd0);
    @(negedge clk);
    bus.arready = 1'b0;
    for (int i = 0; i < rWait; i++) begin
      bus.rvalid = 1'b1;
      bus.rlast  = 1'b0;
      bus.rdata  = ~data;
      #1;
      checkOutput({tag, ".wait_rready"}, 64'(bus.rready), 64'd1);
      checkOutput({tag, ".wait_data_ok"}, 64'(bus.inst_sram_data_ok), 64'd0);
      @(negedge clk);
    end
    bus.rvalid = 1'b1;
    bus.rlast  = 1'b1;
    bus.rdata  = data;
    bus.rresp  = resp;
    bus.rid    = 4'h5;
    #1;
    checkOutput({tag, ".rready"}, 64'(bus.rready), 64'd1);
    checkOutput({tag, ".r_arvalid"}, 64'(bus.arvalid), 64'd0);
    @(negedge clk);
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rdata  = 32'h0;
    bus.rresp  = 2'b00;
    #1;
    checkOutput({tag, ".data_ok"}, 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput({tag, ".rdata"}, 64'(bus.inst_sram_rdata), 64'(data));
    checkOutput({tag, ".resp_addr_ok"}, 64'(bus.inst_sram_addr_ok), 64'd0);
    checkOutput({tag, ".resp_rready"}, 64'(bus.rready), 64'd0);
    if (!holdEn) begin
      @(negedge clk);
      #1;
      checkOutput({tag, ".data_ok_pulse"}, 64'(bus.inst_sram_data_ok), 64'd0);
      checkOutput({tag, ".rdata_held"}, 64'(bus.inst_sram_rdata), 64'(data));
      checkOutput({tag, ".post_arvalid"}, 64'(bus.arvalid), 64'd0);
    end
  endtask

  task automatic applyStimulus();
    logic [31:0] words [4];
    words[0] = 32'h3c1d_8000;
    words[1] = 32'h27bd_fff0;
    words[2] = 32'hafbf_000c;
    words[3] = 32'h0c00_0100;

    runFetch("t1_single", 32'hbfc0_0000, 0, 0, 32'h3c1d_8000, 2'b00, 1'b0);
    runFetch("t2_arstall", 32'hbfc0_0040, 5, 2, 32'h1234_abcd, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      runFetch($sformatf("t3_seq%0d", i), 32'hbfc0_0000 + 32'(i * 4), 0, 0, words[i], 2'b00, 1'b1);
    end

    @(negedge clk);
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_wr   = 1'b1;
    bus.inst_sram_addr = 32'h0000_1000;
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("t4_wr_addr_ok", 64'(bus.inst_sram_addr_ok), 64'd0);
      checkOutput("t4_wr_arvalid", 64'(bus.arvalid), 64'd0);
      @(negedge clk);
    end
    bus.inst_sram_en = 1'b0;
    bus.inst_sram_wr = 1'b0;

    runFetch("t6_slverr", 32'h0000_2000, 0, 0, 32'hdead_beef, 2'b10, 1'b0);

    // Reset while the final R beat is on the bus
    @(negedge clk);
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h0000_3000;
    @(negedge clk);
    bus.inst_sram_en = 1'b0;
    bus.arready      = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rlast   = 1'b1;
    bus.rdata   = 32'h5555_aaaa;
    #1;
    checkOutput("t5_in_r", 64'(bus.rready), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.rdata   = 32'h0;
    #1;
    checkOutput("t5_rready", 64'(bus.rready), 64'd0);
    checkOutput("t5_data_ok", 64'(bus.inst_sram_data_ok), 64'd0);
    checkOutput("t5_arvalid", 64'(bus.arvalid), 64'd0);
    checkOutput("t5_rdata", 64'(bus.inst_sram_rdata), 64'd0);
    checkOutput("t5_araddr", 64'(bus.araddr), 64'd0);
    runFetch("t5_fresh", 32'hbfc0_0100, 1, 0, 32'h0800_0042, 2'b00, 1'b0);
  endtask

  initial begin
    assertCount        = 0;
    failCount          = 0;
    reset              = 1'b1;
    bus.inst_sram_en   = 1'b0;
    bus.inst_sram_wr   = 1'b0;
    bus.inst_sram_size = 2'b00;
    bus.inst_sram_wen  = 4'h0;
    bus.inst_sram_addr = 32'h0;
    bus.inst_sram_wdata = 32'h0;
    bus.arready        = 1'b0;
    bus.rid            = 4'h0;
    bus.rdata          = 32'h0;
    bus.rresp          = 2'b00;
    bus.rlast          = 1'b0;
    bus.rvalid         = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_arvalid", 64'(bus.arvalid), 64'd0);
    checkOutput("rst_rready", 64'(bus.rready), 64'd0);
    checkOutput("rst_data_ok", 64'(bus.inst_sram_data_ok), 64'd0);
    checkOutput("rst_araddr", 64'(bus.araddr), 64'd0);
    checkOutput("rst_arsize", 64'(bus.arsize), 64'd2);
    checkOutput("rst_rdata", 64'(bus.inst_sram_rdata), 64'd0);
    checkOutput("rst_arburst", 64'(bus.arburst), 64'd1);
    checkOutput("rst_arlen", 64'(bus.arlen), 64'd0);
    checkOutput("rst_arid", 64'(bus.arid), 64'd0);
    reset = 1'b0;
    applyStimulus();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
